// File: rtl/gt_reset_seq.sv
// rtl/gt_reset_seq.sv - shared PLL/TX reset sequencer with independent per-channel RX reset FSMs
// All state and outputs live on drpclk_in; inputs are resynchronised before use.
module gt_reset_seq #(
   parameter int N_CH        = 4,
   parameter int PLLRST_CYC  = 16,
   parameter int RST_CYC     = 16,
   parameter int USRRDY_DLY  = 64,
   parameter int TIMEOUT_CYC = 65535,
   parameter int VALID_CYC   = 256,
   parameter int INVALID_CYC = 32,
   parameter int MAX_RETRY   = 8
) (
   input  logic              drpclk_in,
   input  logic              soft_reset,
   input  logic              pll_locked_in,
   input  logic [N_CH-1:0]   tx_resetdone_in,
   input  logic [N_CH-1:0]   rx_resetdone_in,
   input  logic [N_CH-1:0]   rx_data_valid_in,
   input  logic              dont_reset_on_data_error_in,
   output logic              pll_reset_out,
   output logic [N_CH-1:0]   gt_txreset_out,
   output logic [N_CH-1:0]   gt_rxreset_out,
   output logic [N_CH-1:0]   txusrrdy_out,
   output logic [N_CH-1:0]   rxusrrdy_out,
   output logic [N_CH-1:0]   tx_fsm_resetdone_out,
   output logic [N_CH-1:0]   rx_fsm_resetdone_out,
   output logic [4*N_CH-1:0] rx_retry_cnt_out,
   output logic [N_CH-1:0]   rx_fail_out
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXP = max2(max2(max2(PLLRST_CYC, RST_CYC), max2(USRRDY_DLY, TIMEOUT_CYC)),
                              max2(VALID_CYC, INVALID_CYC));
   localparam int CW   = $clog2(MAXP + 1);
   localparam int SW   = 1 + 3 * N_CH;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t CNT_MAX      = '1;
   localparam cnt_t PLLRST_LAST  = cnt_t'(PLLRST_CYC - 1);
   localparam cnt_t RST_LAST     = cnt_t'(RST_CYC - 1);
   localparam cnt_t USRRDY_LAST  = cnt_t'(USRRDY_DLY - 1);
   localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYC - 1);
   localparam cnt_t VALID_LAST   = cnt_t'(VALID_CYC - 1);
   localparam cnt_t INVALID_LAST = cnt_t'(INVALID_CYC - 1);

   typedef enum logic [2:0] {
      TPLLRST, TPLLWAIT, TTXRST, TUSRRDY, TWAIT, TDONE
   } tx_state_t;

   typedef enum logic [2:0] {
      RWAIT, RRST, RUSRRDY, RWAITDONE, RVALID, RDONE
   } rx_state_t;

   // Two-flop synchroniser for every asynchronous status input
   logic [SW-1:0] sync_a;
   logic [SW-1:0] sync_b;
   logic [SW-1:0] async_vec;

   assign async_vec = {rx_data_valid_in, rx_resetdone_in, tx_resetdone_in, pll_locked_in};

   always_ff @(posedge drpclk_in or posedge soft_reset) begin
      if (soft_reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= async_vec;
         sync_b <= sync_a;
      end
   end

   logic            locked;
   logic [N_CH-1:0] tx_rd_s;
   logic [N_CH-1:0] rx_rd_s;
   logic [N_CH-1:0] rx_v_s;

   assign locked  = sync_b[0];
   assign tx_rd_s = sync_b[N_CH:1];
   assign rx_rd_s = sync_b[2*N_CH:N_CH+1];
   assign rx_v_s  = sync_b[3*N_CH:2*N_CH+1];

   tx_state_t tx_state;
   tx_state_t tx_nxt;
   cnt_t      tx_cnt;
   cnt_t      tx_cnt_nxt;

   always_comb begin
      tx_nxt     = tx_state;
      tx_cnt_nxt = (tx_cnt == CNT_MAX) ? tx_cnt : tx_cnt + 1'b1;
      case (tx_state)
         TPLLRST:  if (tx_cnt == PLLRST_LAST) tx_nxt = TPLLWAIT;
         TPLLWAIT: begin
            if (locked)                       tx_nxt = TTXRST;
            else if (tx_cnt == TIMEOUT_LAST)  tx_nxt = TPLLRST;
         end
         TTXRST: begin
            if (!locked)                      tx_nxt = TPLLRST;
            else if (tx_cnt == RST_LAST)      tx_nxt = TUSRRDY;
         end
         TUSRRDY: begin
            if (!locked)                      tx_nxt = TPLLRST;
            else if (tx_cnt == USRRDY_LAST)   tx_nxt = TWAIT;
         end
         TWAIT: begin
            if (!locked)                      tx_nxt = TPLLRST;
            else if (&tx_rd_s)                tx_nxt = TDONE;
            else if (tx_cnt == TIMEOUT_LAST)  tx_nxt = TTXRST;
         end
         TDONE:    if (!locked) tx_nxt = TPLLRST;
         default:  tx_nxt = TPLLRST;
      endcase
      if (tx_nxt != tx_state) tx_cnt_nxt = '0;
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge drpclk_in or posedge soft_reset) begin
      if (soft_reset) begin
         tx_state             <= TPLLRST;
         tx_cnt               <= '0;
         pll_reset_out        <= 1'b1;
         gt_txreset_out       <= '1;
         txusrrdy_out         <= '0;
         tx_fsm_resetdone_out <= '0;
      end else begin
         tx_state             <= tx_nxt;
         tx_cnt               <= tx_cnt_nxt;
         pll_reset_out        <= (tx_nxt == TPLLRST);
         gt_txreset_out       <= {N_CH{tx_nxt == TTXRST}};
         txusrrdy_out         <= {N_CH{(tx_nxt == TWAIT) || (tx_nxt == TDONE)}};
         tx_fsm_resetdone_out <= {N_CH{tx_nxt == TDONE}};
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_rx
      rx_state_t  state;
      rx_state_t  nxt;
      cnt_t       cnt;
      cnt_t       cnt_nxt;
      logic       retry;
      logic [3:0] retry_cnt;
      logic [3:0] retry_inc;
      logic       fail_q;
      logic       rxreset_q;
      logic       usrrdy_q;
      logic       done_q;

      assign retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

      always_comb begin
         nxt     = state;
         retry   = 1'b0;
         cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
         // Loss of lock outranks every in-state event, including a timeout
         if (!locked) begin
            nxt = RWAIT;
         end else begin
            case (state)
               RWAIT:     nxt = RRST;
               RRST:      if (cnt == RST_LAST) nxt = RUSRRDY;
               RUSRRDY:   if (cnt == USRRDY_LAST) nxt = RWAITDONE;
               RWAITDONE: begin
                  if (rx_rd_s[k])                 nxt   = RVALID;
                  else if (cnt == TIMEOUT_LAST)   retry = 1'b1;
               end
               RVALID: begin
                  if (!rx_v_s[k])                 cnt_nxt = '0;
                  else if (cnt == VALID_LAST)     nxt     = RDONE;
               end
               RDONE: begin
                  if (rx_v_s[k]) begin
                     cnt_nxt = '0;
                  end else if (cnt == INVALID_LAST) begin
                     if (dont_reset_on_data_error_in) cnt_nxt = cnt;
                     else                             retry   = 1'b1;
                  end
               end
               default:   nxt = RWAIT;
            endcase
         end
         if (retry) nxt = RRST;
         if (nxt != state) cnt_nxt = '0;
      end

      always_ff @(posedge drpclk_in or posedge soft_reset) begin
         if (soft_reset) begin
            state     <= RWAIT;
            cnt       <= '0;
            retry_cnt <= '0;
            fail_q    <= 1'b0;
            rxreset_q <= 1'b1;
            usrrdy_q  <= 1'b0;
            done_q    <= 1'b0;
         end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            if (retry) begin
               retry_cnt <= retry_inc;
               if (int'(retry_inc) >= MAX_RETRY) fail_q <= 1'b1;
            end
            rxreset_q <= (nxt == RRST);
            usrrdy_q  <= (nxt == RWAITDONE) || (nxt == RVALID) || (nxt == RDONE);
            done_q    <= (nxt == RDONE);
         end
      end

      assign gt_rxreset_out[k]         = rxreset_q;
      assign rxusrrdy_out[k]           = usrrdy_q;
      assign rx_fsm_resetdone_out[k]   = done_q;
      assign rx_fail_out[k]            = fail_q;
      assign rx_retry_cnt_out[4*k +: 4] = retry_cnt;
   end

endmodule

// File: tb/tb_gt_reset_seq.sv
// tb/tb_gt_reset_seq.sv - directed/randomised bench for gt_reset_seq with an event-timing reference model
module tb_gt_reset_seq;
   localparam int N_CH = 2;
   localparam int PC   = 4;    // PLLRST_CYC
   localparam int RC   = 3;    // RST_CYC
   localparam int UC   = 5;    // USRRDY_DLY
   localparam int TC   = 20;   // TIMEOUT_CYC
   localparam int VC   = 8;    // VALID_CYC
   localparam int IC   = 4;    // INVALID_CYC
   localparam int MR   = 3;    // MAX_RETRY
   localparam int LAT  = 3;    // input change to registered reaction: 2 sync flops + state

   localparam int S_PLL = 0, S_TXR = 1, S_RXR = 2, S_TXU = 3, S_RXU = 4;
   localparam int S_TXD = 5, S_RXD = 6, S_RETRY = 7, S_FAIL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            soft_reset;
   logic            pll_locked;
   logic [N_CH-1:0] tx_rd, rx_rd, rx_v;
   logic            dont_reset;
   logic            pll_reset;
   logic [N_CH-1:0] gt_txreset, gt_rxreset, txusrrdy, rxusrrdy, tx_done, rx_done, rx_fail;
   logic [4*N_CH-1:0] retry;

   gt_reset_seq #(
      .N_CH(N_CH), .PLLRST_CYC(PC), .RST_CYC(RC), .USRRDY_DLY(UC), .TIMEOUT_CYC(TC),
      .VALID_CYC(VC), .INVALID_CYC(IC), .MAX_RETRY(MR)
   ) dut (
      .drpclk_in(clk), .soft_reset(soft_reset), .pll_locked_in(pll_locked),
      .tx_resetdone_in(tx_rd), .rx_resetdone_in(rx_rd), .rx_data_valid_in(rx_v),
      .dont_reset_on_data_error_in(dont_reset), .pll_reset_out(pll_reset),
      .gt_txreset_out(gt_txreset), .gt_rxreset_out(gt_rxreset), .txusrrdy_out(txusrrdy),
      .rxusrrdy_out(rxusrrdy), .tx_fsm_resetdone_out(tx_done), .rx_fsm_resetdone_out(rx_done),
      .rx_retry_cnt_out(retry), .rx_fail_out(rx_fail)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int usr_cnt = 0;
   always @(negedge clk) if ((|txusrrdy) || (|rxusrrdy)) usr_cnt <= usr_cnt + 1;

   int n_tests = 0, n_fail = 0;
   int c0, t, lk, e, g, r, k, d, w, pd, snap;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int probe(input int sel);
      case (sel)
         S_PLL:   return int'(pll_reset);
         S_TXR:   return int'(gt_txreset);
         S_RXR:   return int'(gt_rxreset);
         S_TXU:   return int'(txusrrdy);
         S_RXU:   return int'(rxusrrdy);
         S_TXD:   return int'(tx_done);
         S_RXD:   return int'(rx_done);
         S_RETRY: return int'(retry);
         S_FAIL:  return int'(rx_fail);
         default: return -1;
      endcase
   endfunction

   // Returns the cycle at which the output first matches, or -1 when the budget runs out
   task automatic wait_for(input int sel, input int val, input int budget, output int tt);
      int i;
      i  = 0;
      tt = -1;
      while (tt < 0 && i < budget) begin
         if (probe(sel) == val) tt = cyc;
         else begin
            @(negedge clk);
            i++;
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_pll"},    probe(S_PLL),   1);
      chk({tag, "_txrst"},  probe(S_TXR),   3);
      chk({tag, "_rxrst"},  probe(S_RXR),   3);
      chk({tag, "_txusr"},  probe(S_TXU),   0);
      chk({tag, "_rxusr"},  probe(S_RXU),   0);
      chk({tag, "_txdone"}, probe(S_TXD),   0);
      chk({tag, "_rxdone"}, probe(S_RXD),   0);
      chk({tag, "_retry"},  probe(S_RETRY), 0);
      chk({tag, "_fail"},   probe(S_FAIL),  0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      soft_reset = 1'b1;
      #1;
      check_reset(tag);
      step(2);
      soft_reset = 1'b0;
      c0 = cyc;
   endtask

   // PLL pulse must end PC cycles after c0; lock then rises after a random gap
   task automatic bringup(output int lock_cyc);
      int tt;
      wait_for(S_PLL, 0, 100, tt);
      chk("pll_fall", tt, c0 + PC);
      step($urandom_range(6, 12));
      pll_locked = 1'b1;
      lock_cyc = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      soft_reset = 1'b1;
      pll_locked = 1'b0;
      tx_rd      = '1;
      rx_rd      = '1;
      rx_v       = '1;
      dont_reset = 1'b0;
      step(2);

      // Nominal bring-up with a single-cycle valid glitch on channel 0 during RVALID
      do_reset("rst0");
      bringup(lk);
      wait_for(S_TXR, 3, 50, t);  chk("txrst_rise", t, lk + LAT);
      chk("rxrst_rise", probe(S_RXR), 3);
      wait_for(S_TXR, 0, 50, t);  chk("txrst_fall", t, lk + LAT + RC);
      wait_for(S_TXU, 3, 50, t);  chk("txusr_rise", t, lk + LAT + RC + UC);
      chk("rxusr_rise", probe(S_RXU), 3);
      chk("txdone_pre", probe(S_TXD), 0);
      e = lk + LAT + RC + UC + 1;
      step(1);
      chk("txdone", probe(S_TXD), 3);
      chk("txdone_cyc", cyc, e);
      r = $urandom_range(2, VC - 1);
      g = e - 2 + r;
      to_cyc(g);
      rx_v[0] = 1'b0;
      step(1);
      rx_v[0] = 1'b1;
      wait_for(S_RXD, 2, 50, t);  chk("rxdone_ch1", t, e + VC);
      wait_for(S_RXD, 3, 50, t);  chk("rxdone_ch0_glitch", t, g + LAT + VC);
      chk("retry_nominal", probe(S_RETRY), 0);

      // Short invalid burst on channel 1 is tolerated, a full one re-resets only channel 1
      k = $urandom_range(1, IC - 1);
      rx_v[1] = 1'b0;
      step(k);
      rx_v[1] = 1'b1;
      step(IC + 3);
      chk("short_invalid_done", probe(S_RXD), 3);
      chk("short_invalid_retry", probe(S_RETRY), 0);
      g = cyc;
      rx_v[1] = 1'b0;
      step(IC);
      rx_v[1] = 1'b1;
      wait_for(S_RXD, 1, 20, t);  chk("invalid_rereset", t, g + LAT - 1 + IC);
      chk("invalid_retry_cnt", probe(S_RETRY), 16);
      chk("invalid_rxrst", probe(S_RXR), 2);
      chk("invalid_txdone", probe(S_TXD), 3);
      wait_for(S_RXD, 3, 100, t); chk("invalid_redone", t, g + LAT - 1 + IC + RC + UC + 1 + VC);

      dont_reset = 1'b1;
      rx_v[1] = 1'b0;
      step(3 * IC);
      rx_v[1] = 1'b1;
      step(4);
      chk("dont_reset_done", probe(S_RXD), 3);
      chk("dont_reset_retry", probe(S_RETRY), 16);
      chk("dont_reset_rxrst", probe(S_RXR), 0);
      dont_reset = 1'b0;

      // Lock loss from the fully done state
      d = cyc;
      pll_locked = 1'b0;
      step(2);
      chk("lockdrop_hold", probe(S_TXD), 3);
      step(1);
      chk("lockdrop_txdone", probe(S_TXD), 0);
      chk("lockdrop_rxdone", probe(S_RXD), 0);
      chk("lockdrop_txusr", probe(S_TXU), 0);
      chk("lockdrop_rxusr", probe(S_RXU), 0);
      chk("lockdrop_pll", probe(S_PLL), 1);
      c0 = d + LAT;
      bringup(lk);
      wait_for(S_TXD, 3, 100, t); chk("relock_txdone", t, lk + LAT + RC + UC + 1);
      wait_for(S_RXD, 3, 100, t); chk("relock_rxdone", t, lk + LAT + RC + UC + 1 + VC);
      chk("relock_retry", probe(S_RETRY), 16);

      // Asynchronous reset while the channels sit in RVALID
      pll_locked = 1'b0;
      do_reset("rst1");
      bringup(lk);
      wait_for(S_RXU, 3, 100, t); chk("rvalid_rxusr", t, lk + LAT + RC + UC);
      step(2);
      #1 soft_reset = 1'b1;
      #1 check_reset("rvalid_rst");

      // Channel 0 never sees resetdone: timeouts, fail at MR, saturation at 15
      rx_rd = 2'b10;
      pll_locked = 1'b0;
      do_reset("rst2");
      bringup(lk);
      w = lk + LAT + RC + UC;
      to_cyc(w + TC - LAT);
      pll_locked = 1'b0;
      to_cyc(w + TC);
      chk("lock_beats_timeout_retry", probe(S_RETRY), 0);
      chk("lock_beats_timeout_rxusr", probe(S_RXU), 0);
      c0 = w + TC;
      bringup(lk);
      w  = lk + LAT + RC + UC;
      pd = RC + UC + TC;
      wait_for(S_RETRY, 1, 200, t);   chk("timeout_retry1", t, w + TC);
      wait_for(S_FAIL, 1, 500, t);    chk("fail_rise", t, w + TC + (MR - 1) * pd);
      chk("fail_retry_cnt", probe(S_RETRY), MR);
      wait_for(S_RETRY, 15, 1000, t); chk("retry_sat_time", t, w + TC + 14 * pd);
      step(2 * pd);
      chk("retry_saturated", probe(S_RETRY), 15);
      chk("fail_sticky", probe(S_FAIL), 1);
      chk("ch1_done_during_fail", probe(S_RXD), 2);
      chk("tx_done_during_fail", probe(S_TXD), 3);

      // Lock never rises: PLL reset re-pulses, no usrrdy ever
      rx_rd = '1;
      pll_locked = 1'b0;
      do_reset("rst3");
      step(1);
      snap = usr_cnt;
      wait_for(S_PLL, 0, 100, t); chk("nolock_fall1", t, c0 + PC);
      wait_for(S_PLL, 1, 100, t); chk("nolock_rise1", t, c0 + PC + TC);
      wait_for(S_PLL, 0, 100, t); chk("nolock_fall2", t, c0 + 2 * PC + TC);
      wait_for(S_PLL, 1, 100, t); chk("nolock_rise2", t, c0 + 2 * PC + 2 * TC);
      chk("nolock_usrrdy_cycles", usr_cnt - snap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
